// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions: polynomial taps, pattern FSM states, step function.
// Used by the pattern generator and the lock checker so both ends agree.
package lfsr_pkg;

    localparam int LFSR_W = 8;

    typedef logic [LFSR_W-1:0] lfsr_t;

    // x^8 + x^6 + x^5 + x^4 + 1 : feedback from bits 7, 5, 4, 3
    localparam lfsr_t TAPS = 8'hB8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        GAP   = 2'd2
    } state_e;

    function automatic lfsr_t lfsr_next(input lfsr_t s);
        return {s[LFSR_W-2:0], ^(s & TAPS)};
    endfunction

endpackage

// File: rtl/lfsr_core.sv
// Fibonacci LFSR state register with load, step and hold.
// A zero load value is replaced by the reset seed to avoid the lock-up state.
module lfsr_core
    import lfsr_pkg::*;
#(
    parameter lfsr_t RESET_SEED = '1
) (
    input  logic  clk,
    input  logic  i_reset_n,
    input  logic  i_load,
    input  lfsr_t i_load_val,
    input  logic  i_step,
    output lfsr_t o_state
);

    lfsr_t state_d;
    lfsr_t state_q;

    // Next state: load has priority over step; otherwise hold.
    always_comb begin
        state_d = state_q;
        if (i_load) begin
            state_d = (i_load_val == '0) ? RESET_SEED : i_load_val;
        end else if (i_step) begin
            state_d = lfsr_next(state_q);
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!i_reset_n) begin
            state_q <= RESET_SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign o_state = state_q;

endmodule

// File: rtl/lfsr_pattern_gen.sv
// PRBS source with programmable valid/gap bursts and periodic error injection.
// The LFSR state is never corrupted; only the emitted word has bit 0 flipped.
module lfsr_pattern_gen
    import lfsr_pkg::*;
#(
    parameter int                     LFSR_WIDTH = 8,
    parameter logic [LFSR_WIDTH-1:0]  RESET_SEED = {LFSR_WIDTH{1'b1}},
    parameter int                     PAT_W      = 8,
    parameter int                     ERR_W      = 16
) (
    input  logic                  clk,
    input  logic                  i_reset_n,
    input  logic                  i_soft_reset,
    input  logic [LFSR_WIDTH-1:0] i_seed,
    input  logic                  i_enable,
    input  logic [PAT_W-1:0]      i_burst_len,
    input  logic [PAT_W-1:0]      i_gap_len,
    input  logic [ERR_W-1:0]      i_err_period,
    output logic [LFSR_WIDTH-1:0] o_LFSR,
    output logic                  o_valid,
    output logic                  o_err_injected,
    output logic [ERR_W-1:0]      o_word_count
);

    state_e                state_d, state_q;
    logic [PAT_W-1:0]      burst_len_d, burst_len_q;
    logic [PAT_W-1:0]      gap_len_d, gap_len_q;
    logic [ERR_W-1:0]      err_period_d, err_period_q;
    logic [PAT_W-1:0]      burst_cnt_d, burst_cnt_q;
    logic [PAT_W-1:0]      gap_cnt_d, gap_cnt_q;
    logic [ERR_W-1:0]      err_cnt_d, err_cnt_q;
    logic [ERR_W-1:0]      word_cnt_d, word_cnt_q;
    logic [LFSR_WIDTH-1:0] lfsr_d, lfsr_q;
    logic                  valid_d, valid_q;
    logic                  err_d, err_q;

    logic [PAT_W-1:0]      eff_burst, eff_gap;
    logic [ERR_W-1:0]      eff_err;
    logic [PAT_W-1:0]      burst_inc, gap_inc;
    logic [ERR_W-1:0]      err_inc;
    logic                  emit, inj;
    lfsr_t                 s;

    lfsr_core #(
        .RESET_SEED (RESET_SEED)
    ) u_core (
        .clk        (clk),
        .i_reset_n  (i_reset_n),
        .i_load     (i_soft_reset),
        .i_load_val (i_seed),
        .i_step     (emit),
        .o_state    (s)
    );

    assign burst_inc = burst_cnt_q + 1'b1;
    assign gap_inc   = gap_cnt_q + 1'b1;
    assign err_inc   = err_cnt_q + 1'b1;

    // Pattern FSM, counters, error injection and output word formation.
    always_comb begin
        state_d      = state_q;
        burst_len_d  = burst_len_q;
        gap_len_d    = gap_len_q;
        err_period_d = err_period_q;
        burst_cnt_d  = burst_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        err_cnt_d    = err_cnt_q;
        word_cnt_d   = word_cnt_q;
        lfsr_d       = lfsr_q;
        valid_d      = 1'b0;
        err_d        = 1'b0;
        emit         = 1'b0;
        inj          = 1'b0;
        // Leaving IDLE emits a word using the controls being latched now.
        eff_burst    = (state_q == IDLE) ? i_burst_len  : burst_len_q;
        eff_gap      = (state_q == IDLE) ? i_gap_len    : gap_len_q;
        eff_err      = (state_q == IDLE) ? i_err_period : err_period_q;

        if (i_soft_reset) begin
            state_d     = IDLE;
            burst_cnt_d = '0;
            gap_cnt_d   = '0;
            err_cnt_d   = '0;
            word_cnt_d  = '0;
        end else if (!i_enable) begin
            state_d     = IDLE;
            burst_cnt_d = '0;
            gap_cnt_d   = '0;
        end else if (state_q == GAP) begin
            if (gap_inc == gap_len_q) begin
                state_d      = BURST;
                gap_cnt_d    = '0;
                burst_len_d  = i_burst_len;
                gap_len_d    = i_gap_len;
                err_period_d = i_err_period;
            end else begin
                gap_cnt_d = gap_inc;
            end
        end else begin
            emit = 1'b1;
        end

        if (emit) begin
            state_d = BURST;
            if (state_q == IDLE) begin
                burst_len_d  = i_burst_len;
                gap_len_d    = i_gap_len;
                err_period_d = i_err_period;
            end
            if (eff_err != '0) begin
                if (err_inc == eff_err) begin
                    inj       = 1'b1;
                    err_cnt_d = '0;
                end else begin
                    err_cnt_d = err_inc;
                end
            end
            if (eff_burst == '0) begin
                burst_cnt_d = '0;
            end else if (burst_inc == eff_burst) begin
                burst_cnt_d = '0;
                if (eff_gap != '0) begin
                    state_d = GAP;
                end else begin
                    burst_len_d  = i_burst_len;
                    gap_len_d    = i_gap_len;
                    err_period_d = i_err_period;
                end
            end else begin
                burst_cnt_d = burst_inc;
            end
            lfsr_d  = s ^ {{(LFSR_WIDTH-1){1'b0}}, inj};
            valid_d = 1'b1;
            err_d   = inj;
            if (word_cnt_q != '1) begin
                word_cnt_d = word_cnt_q + 1'b1;
            end
        end
    end

    // All state and registered outputs, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!i_reset_n) begin
            state_q      <= IDLE;
            burst_len_q  <= '0;
            gap_len_q    <= '0;
            err_period_q <= '0;
            burst_cnt_q  <= '0;
            gap_cnt_q    <= '0;
            err_cnt_q    <= '0;
            word_cnt_q   <= '0;
            lfsr_q       <= '0;
            valid_q      <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            burst_len_q  <= burst_len_d;
            gap_len_q    <= gap_len_d;
            err_period_q <= err_period_d;
            burst_cnt_q  <= burst_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            err_cnt_q    <= err_cnt_d;
            word_cnt_q   <= word_cnt_d;
            lfsr_q       <= lfsr_d;
            valid_q      <= valid_d;
            err_q        <= err_d;
        end
    end

    assign o_LFSR         = lfsr_q;
    assign o_valid        = valid_q;
    assign o_err_injected = err_q;
    assign o_word_count   = word_cnt_q;

endmodule
